acc_cpu_ws: RTL and testbench
=============================

# acc_cpu_ws

Parametrised accumulator CPU, next generation of the team's fetch/execute accumulator machine. Generalises data and address width, adds a req/ack memory handshake with unbounded wait states, adds SUB/XOR, HALT and (optionally) conditional branches. Sits between the instruction/data memory (single shared port) and the top level; one instruction completes per fetch + execute sequence.

## Interface
- DATA_W, 32, accumulator/instruction/memory word width; must be ≥ ADDR_W+4
- ADDR_W, 16, address width; operand field is IR[ADDR_W-1:0], opcode is IR[DATA_W-1:DATA_W-4]
- RESET_PC, 0, PC value loaded on reset
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- address  out  ADDR_W  memory address: PC in FETCH, IR operand field in EXEC
- data_out  out  DATA_W  store data, always equals AC
- we  out  1  write enable, high only in EXEC of ST while req high
- req  out  1  memory request; held until accepted by ack
- ack  in  1  memory ready; access completes on the rising edge where req & ack
- data_in  in  DATA_W  read data, sampled on the completing edge
- halted  out  1  high in HALT state

## Operation
- States: FETCH, EXEC, HALT.
- FETCH: req=1, address=PC. On req&ack: IR<=data_in, PC<=PC+1 (wraps mod 2^ADDR_W), ->EXEC. Without ack: hold all state.
- EXEC, memory opcodes (ADD, SHL, SHR, LD, OR, ST, AND, SUB, XOR): req=1, address=IR operand. Update on req&ack, then ->FETCH. Without ack: hold.
- EXEC, non-memory opcodes (NOP, LDI, BR, BRZ, BRN, HALT): req=0, complete in one cycle.
- Opcodes: 0000 NOP; 0001 ADD AC+=M; 0010 SHL AC<<=M; 0011 SHR AC>>=M (logical); 0100 LDI AC<=zero-extended operand; 0101 LD AC<=M; 0110 OR; 0111 ST M<=AC; 1000 BR PC<=operand; 1001 AND; 1010 BRZ; 1011 BRN; 1100 SUB AC-=M; 1101 XOR; 1110 NOP; 1111 HALT ->HALT.
- Arithmetic modulo 2^DATA_W, no carry/overflow kept. Shift by M ≥ DATA_W (full DATA_W-bit compare) gives 0.
- BRZ taken if AC==0; BRN taken if AC[DATA_W-1]==1; not taken = NOP.
- HALT: req=0, we=0, halted=1; left only by reset.

## Timing
- Reset (reset low, async): state=FETCH, PC=RESET_PC, AC=0, IR=0. While reset low: req=0, we=0, halted=0, data_out=0, address=RESET_PC.
- First req rises with reset deassert (combinational from state); first fetch completes on first edge with ack high.
- ack tied high: memory instruction = 2 cycles, non-memory = 2 cycles (fetch + 1).
- Each wait cycle (req & !ack) adds exactly one cycle; address, we, data_out stable throughout.
- ack while req=0 is ignored.
- Reset asserted mid-access aborts it; no partial AC/PC/IR update; ST with reset low never asserts we.
- we is combinational: we = (state==EXEC) & (op==ST) & reset high.

## Configuration
- ACC_CPU_COND_BRANCH_EN defined: BRZ/BRN decode as above.
- Not defined: 1010 and 1011 execute as NOP (one cycle, no req, PC unchanged beyond fetch increment).

## Test plan
- Reset then ack=1, memory: 0:LDI 5, 1:ADD [10] (M[10]=7), 2:ST [11], 3:HALT -> M[11]=12, halted=1 after 8 cycles, req=0 thereafter.
- Same program with ack low 3 cycles on every access -> identical result; address/we stable during every wait; 3 extra cycles per memory access.
- Wrap/saturate: DATA_W=32, AC=0xFFFFFFFF ADD M=1 -> AC=0; SHL by M=32 -> AC=0; SUB 0-1 -> 0xFFFFFFFF.
- With ACC_CPU_COND_BRANCH_EN: AC=0 BRZ 0x20 -> next fetch address 0x20; AC=0x80000000 BRN taken; AC=1 both not taken. Without macro: both fall through.
- Reset pulsed low during EXEC of ST with ack low -> we never high, memory unchanged, next fetch from RESET_PC with AC=0.
- PC wrap: ADDR_W=4, RESET_PC=15, NOP at 15 -> next fetch address 0.

Source files
------------

// File: rtl/acc_cpu_ws.sv
// acc_cpu_ws: parametrised fetch/execute accumulator CPU on a single shared req/ack memory port.
// Optional feature macro ACC_CPU_COND_BRANCH_EN enables BRZ/BRN; otherwise those opcodes run as NOP.
module acc_cpu_ws #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] data_out_o,
    output logic              we_o,
    output logic              req_o,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              halted_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SHL  = 4'h2,
        OP_SHR  = 4'h3,
        OP_LDI  = 4'h4,
        OP_LD   = 4'h5,
        OP_OR   = 4'h6,
        OP_ST   = 4'h7,
        OP_BR   = 4'h8,
        OP_AND  = 4'h9,
        OP_BRZ  = 4'hA,
        OP_BRN  = 4'hB,
        OP_SUB  = 4'hC,
        OP_XOR  = 4'hD,
        OP_NOP2 = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);
    localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    opcode_e           ir_op_q, ir_op_d;
    logic [ADDR_W-1:0] ir_opd_q, ir_opd_d;

    logic              mem_op_s;
    logic              xfer_s;
    logic              taken_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] alu_s;

    function automatic logic is_mem_op_f(input opcode_e op);
        logic r;
        case (op)
            OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
            OP_ST, OP_AND, OP_SUB, OP_XOR: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Shift amounts are compared at full width so huge M values flush to zero.
    function automatic logic [DATA_W-1:0] alu_f(input opcode_e           op,
                                                input logic [DATA_W-1:0] ac,
                                                input logic [DATA_W-1:0] m,
                                                input logic [DATA_W-1:0] imm);
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADD:  r = ac + m;
            OP_SUB:  r = ac - m;
            OP_SHL:  r = (m >= SHIFT_LIM) ? {DATA_W{1'b0}} : (ac << m);
            OP_SHR:  r = (m >= SHIFT_LIM) ? {DATA_W{1'b0}} : (ac >> m);
            OP_LD:   r = m;
            OP_LDI:  r = imm;
            OP_OR:   r = ac | m;
            OP_AND:  r = ac & m;
            OP_XOR:  r = ac ^ m;
            default: r = ac;
        endcase
        return r;
    endfunction

`ifdef ACC_CPU_COND_BRANCH_EN
    function automatic logic branch_taken_f(input opcode_e op, input logic [DATA_W-1:0] ac);
        logic t;
        case (op)
            OP_BR:   t = 1'b1;
            OP_BRZ:  t = (ac == {DATA_W{1'b0}});
            OP_BRN:  t = ac[DATA_W-1];
            default: t = 1'b0;
        endcase
        return t;
    endfunction
`else
    function automatic logic branch_taken_f(input opcode_e op);
        logic t;
        case (op)
            OP_BR:   t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction
`endif

    // Decode of the latched instruction and the execute-stage datapath result.
    always_comb begin
        mem_op_s = is_mem_op_f(ir_op_q);
        imm_s    = {{(DATA_W-ADDR_W){1'b0}}, ir_opd_q};
        alu_s    = alu_f(ir_op_q, ac_q, data_in_i, imm_s);
`ifdef ACC_CPU_COND_BRANCH_EN
        taken_s  = branch_taken_f(ir_op_q, ac_q);
`else
        taken_s  = branch_taken_f(ir_op_q);
`endif
    end

    // Memory port: req/we are gated by reset so nothing is requested or written while in reset.
    always_comb begin
        req_o      = 1'b0;
        we_o       = 1'b0;
        address_o  = pc_q;
        data_out_o = ac_q;
        halted_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_o     = reset_ni;
                address_o = pc_q;
            end
            S_EXEC: begin
                req_o     = reset_ni & mem_op_s;
                we_o      = reset_ni & (ir_op_q == OP_ST);
                address_o = ir_opd_q;
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                req_o = 1'b0;
            end
        endcase
        xfer_s = req_o & ack_i;
    end

    // Next-state logic: every state holds all registers until its access completes.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ac_d     = ac_q;
        ir_op_d  = ir_op_q;
        ir_opd_d = ir_opd_q;
        case (state_q)
            S_FETCH: begin
                if (xfer_s) begin
                    ir_op_d  = opcode_e'(data_in_i[DATA_W-1 -: 4]);
                    ir_opd_d = data_in_i[ADDR_W-1:0];
                    pc_d     = pc_q + PC_ONE;
                    state_d  = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (ir_op_q == OP_HALT) begin
                    state_d = S_HALT;
                end else if (mem_op_s) begin
                    if (xfer_s) begin
                        ac_d    = alu_s;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else begin
                    ac_d    = alu_s;
                    pc_d    = taken_s ? ir_opd_q : pc_q;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ac_q     <= {DATA_W{1'b0}};
            ir_op_q  <= OP_NOP;
            ir_opd_q <= {ADDR_W{1'b0}};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ac_q     <= ac_d;
            ir_op_q  <= ir_op_d;
            ir_opd_q <= ir_opd_d;
        end
    end

endmodule

// File: tb/tb_acc_cpu_ws.sv
// Scoreboard bench for acc_cpu_ws: expected memory accesses are queued with each program and
// matched against completed req&ack transfers; a second small instance covers PC wrap.
module tb_acc_cpu_ws;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [31:0] data;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        we, req, ack, halted;
    logic [31:0] prog [256];
    int          wait_n = 0;
    int          wait_cnt;

    logic [3:0]  address2;
    logic [7:0]  data_out2;
    logic [7:0]  data_in2;
    logic        we2, req2, halted2;
    logic [7:0]  prog2 [16];

    acc_t exp_q[$];
    acc_t act_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   stab_err = 0;
    logic in_acc = 1'b0;
    acc_t held;
    int   cyc;

    always #5 clk = ~clk;

    assign data_in  = prog[address[7:0]];
    assign ack      = (wait_cnt == wait_n);
    assign data_in2 = prog2[address2];

    acc_cpu_ws u_dut (
        .clock_i   (clk),
        .reset_ni  (rst_n),
        .address_o (address),
        .data_out_o(data_out),
        .we_o      (we),
        .req_o     (req),
        .ack_i     (ack),
        .data_in_i (data_in),
        .halted_o  (halted)
    );

    acc_cpu_ws #(.DATA_W(8), .ADDR_W(4), .RESET_PC(4'd15)) u_dut_small (
        .clock_i   (clk),
        .reset_ni  (rst_n),
        .address_o (address2),
        .data_out_o(data_out2),
        .we_o      (we2),
        .req_o     (req2),
        .ack_i     (1'b1),
        .data_in_i (data_in2),
        .halted_o  (halted2)
    );

    // Wait-state generator: ack rises after wait_n stalled cycles of each access.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          wait_cnt <= 0;
        else if (req && ack) wait_cnt <= 0;
        else if (req)        wait_cnt <= wait_cnt + 1;
    end

    // Access monitor: logs completed transfers and counts port changes during waits.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_acc <= 1'b0;
        end else if (req) begin
            if (in_acc && (held !== {address, we, data_out})) stab_err <= stab_err + 1;
            if (!in_acc) held <= {address, we, data_out};
            if (ack) begin
                act_q.push_back({address, we, data_out});
                in_acc <= 1'b0;
            end else begin
                in_acc <= 1'b1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [15:0] opd);
        return {op, 12'h000, opd};
    endfunction

    task automatic rd(input logic [15:0] a);
        exp_q.push_back({a, 1'b0, 32'h0});
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back({a, 1'b1, d});
    endtask

    task automatic drain();
        acc_t a, e;
        while (act_q.size() > 0) begin
            a = act_q.pop_front();
            check_val("sb_has_expect", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("acc_addr", 64'(a.addr), 64'(e.addr));
                check_val("acc_we", 64'(a.we), 64'(e.we));
                if (e.we) check_val("acc_data", 64'(a.data), 64'(e.data));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
        drain();
    endtask

    task automatic run_halt(input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        check_val("halt_in_budget", 64'(halted), 64'd1);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        act_q.delete();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic end_test(input string tag);
        check_val({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check_val({tag, "_stable"}, 64'(stab_err), 64'd0);
    endtask

    task automatic load_basic();
        prog[0]  = ins(4'h4, 16'd5);
        prog[1]  = ins(4'h1, 16'd10);
        prog[2]  = ins(4'h7, 16'd11);
        prog[3]  = ins(4'hF, 16'd0);
        prog[10] = 32'd7;
        rd(16'd0); rd(16'd1); rd(16'd10); rd(16'd2); wr(16'd11, 32'd12); rd(16'd3);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prog2[i] = 8'h00;
        prog2[0] = 8'hF0;
        enter_reset();
        #1;
        check_val("rst_req", 64'(req), 64'd0);
        check_val("rst_we", 64'(we), 64'd0);
        check_val("rst_halted", 64'(halted), 64'd0);
        check_val("rst_data_out", 64'(data_out), 64'd0);
        check_val("rst_address", 64'(address), 64'd0);
        check_val("rst_small_address", 64'(address2), 64'd15);

        // Basic program with ack tied high.
        wait_n = 0;
        load_basic();
        release_reset();
        check_val("first_req", 64'(req), 64'd1);
        check_val("first_addr", 64'(address), 64'd0);
        run_halt(60, cyc);
        check_val("basic_cycles", 64'(cyc), 64'd8);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("halt_req_low", 64'(req), 64'd0);
            check_val("halt_we_low", 64'(we), 64'd0);
        end
        end_test("basic");

        // Same program, three wait cycles on every access.
        enter_reset();
        wait_n = 3;
        load_basic();
        release_reset();
        run_halt(100, cyc);
        check_val("wait_cycles", 64'(cyc), 64'd26);
        end_test("wait");

        // Arithmetic wrap, wide shift amounts and logic ops.
        enter_reset();
        wait_n = 1;
        prog[0]  = ins(4'h0, 16'd0);   prog[1]  = ins(4'hE, 16'd0);
        prog[2]  = ins(4'h5, 16'd20);  prog[3]  = ins(4'h1, 16'd21);
        prog[4]  = ins(4'h7, 16'd30);  prog[5]  = ins(4'h4, 16'd1);
        prog[6]  = ins(4'h2, 16'd22);  prog[7]  = ins(4'h7, 16'd31);
        prog[8]  = ins(4'hC, 16'd21);  prog[9]  = ins(4'h7, 16'd32);
        prog[10] = ins(4'hD, 16'd23);  prog[11] = ins(4'h3, 16'd24);
        prog[12] = ins(4'h9, 16'd25);  prog[13] = ins(4'h6, 16'd26);
        prog[14] = ins(4'h7, 16'd33);  prog[15] = ins(4'h2, 16'd24);
        prog[16] = ins(4'h7, 16'd34);  prog[17] = ins(4'h3, 16'd27);
        prog[18] = ins(4'h7, 16'd35);  prog[19] = ins(4'hF, 16'd0);
        prog[20] = 32'hFFFF_FFFF;      prog[21] = 32'h0000_0001;
        prog[22] = 32'd32;             prog[23] = 32'h0F0F_0F0F;
        prog[24] = 32'd4;              prog[25] = 32'h00FF_00FF;
        prog[26] = 32'h3000_0000;      prog[27] = 32'h8000_0001;
        rd(16'd0); rd(16'd1); rd(16'd2); rd(16'd20); rd(16'd3); rd(16'd21);
        rd(16'd4); wr(16'd30, 32'h0);
        rd(16'd5); rd(16'd6); rd(16'd22); rd(16'd7); wr(16'd31, 32'h0);
        rd(16'd8); rd(16'd21); rd(16'd9); wr(16'd32, 32'hFFFF_FFFF);
        rd(16'd10); rd(16'd23); rd(16'd11); rd(16'd24); rd(16'd12); rd(16'd25);
        rd(16'd13); rd(16'd26); rd(16'd14); wr(16'd33, 32'h300F_000F);
        rd(16'd15); rd(16'd24); rd(16'd16); wr(16'd34, 32'h00F0_00F0);
        rd(16'd17); rd(16'd27); rd(16'd18); wr(16'd35, 32'h0);
        rd(16'd19);
        release_reset();
        run_halt(300, cyc);
        end_test("arith");

        // Branches: taken paths need the conditional-branch build, else fall through.
        enter_reset();
        wait_n = 0;
        prog[0]    = ins(4'h4, 16'd0);     prog[1]    = ins(4'hA, 16'h20);
        prog[2]    = ins(4'h5, 16'd40);    prog[3]    = ins(4'hB, 16'h30);
        prog[4]    = ins(4'h7, 16'd42);    prog[5]    = ins(4'hF, 16'd0);
        prog[8'h20] = ins(4'h5, 16'd40);   prog[8'h21] = ins(4'hB, 16'h30);
        prog[8'h30] = ins(4'h4, 16'd1);    prog[8'h31] = ins(4'hA, 16'h50);
        prog[8'h32] = ins(4'hB, 16'h60);   prog[8'h33] = ins(4'h7, 16'd41);
        prog[8'h34] = ins(4'h8, 16'h70);   prog[8'h70] = ins(4'hF, 16'd0);
        prog[40]   = 32'h8000_0000;
`ifdef ACC_CPU_COND_BRANCH_EN
        rd(16'd0); rd(16'd1); rd(16'h20); rd(16'd40); rd(16'h21);
        rd(16'h30); rd(16'h31); rd(16'h32); rd(16'h33); wr(16'd41, 32'd1);
        rd(16'h34); rd(16'h70);
`else
        rd(16'd0); rd(16'd1); rd(16'd2); rd(16'd40); rd(16'd3);
        rd(16'd4); wr(16'd42, 32'h8000_0000); rd(16'd5);
`endif
        release_reset();
        run_halt(100, cyc);
        end_test("branch");

        // Reset pulsed during a stalled ST: no write, restart from RESET_PC with AC cleared.
        enter_reset();
        wait_n = 3;
        prog[0] = ins(4'h4, 16'd9);
        prog[1] = ins(4'h7, 16'd11);
        prog[2] = ins(4'hF, 16'd0);
        rd(16'd0); rd(16'd1);
        release_reset();
        for (int i = 0; i < 40; i++) begin
            if (we) break;
            step();
        end
        check_val("st_reached", 64'(we), 64'd1);
        step();
        check_val("st_still_waiting", 64'(req & ~ack), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_we", 64'(we), 64'd0);
        check_val("abort_req", 64'(req), 64'd0);
        check_val("abort_data_out", 64'(data_out), 64'd0);
        check_val("abort_address", 64'(address), 64'd0);
        step();
        check_val("abort_we_held", 64'(we), 64'd0);
        check_val("abort_sb_empty", 64'(exp_q.size()), 64'd0);
        rd(16'd0); rd(16'd1); wr(16'd11, 32'd9); rd(16'd2);
        release_reset();
        check_val("restart_ac", 64'(data_out), 64'd0);
        check_val("restart_addr", 64'(address), 64'd0);
        run_halt(100, cyc);
        end_test("abort");

        // PC wrap on the 4-bit instance; the main instance just halts at 0.
        enter_reset();
        wait_n = 0;
        prog[0] = ins(4'hF, 16'd0);
        rd(16'd0);
        release_reset();
        check_val("wrap_first_addr", 64'(address2), 64'd15);
        check_val("wrap_first_req", 64'(req2), 64'd1);
        step();
        step();
        check_val("wrap_next_addr", 64'(address2), 64'd0);
        check_val("wrap_next_req", 64'(req2), 64'd1);
        step();
        step();
        check_val("wrap_halted", 64'(halted2), 64'd1);
        check_val("wrap_we", 64'(we2), 64'd0);
        check_val("wrap_data_out", 64'(data_out2), 64'd0);
        end_test("wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
